gray_window_3x3: RTL and testbench
==================================

// Module: gray_window_3x3
// PURPOSE
//  Downstream neighbour of the RGB-to-grayscale stage. Accepts its raster-order 8-bit grayscale pixel stream.
//  Builds a 3x3 neighbourhood window per pixel centre using two internal line delays.
//  Feeds the spatial filter stages (median/Sobel), one window per valid_o pulse.
// PARAMETERS
//  IMG_W   640  pixels per line (>=4)
//  IMG_H   480  lines per frame (>=3)
//  PIX_W   8    bits per grayscale pixel
// PORTS
//  clk       in   1         system clock, all logic on rising edge
//  rst       in   1         asynchronous, active-low reset
//  gray_i    in   PIX_W     grayscale pixel from the grayscale stage
//  valid_i   in   1         gray_i valid this cycle; gaps allowed, no backpressure
//  window_o  out  9*PIX_W   tap k=3*r+c at [PIX_W*k +: PIX_W]; r0 = oldest line, c0 = leftmost
//  valid_o   out  1         window_o valid, one-cycle pulse per window
//  done_o    out  1         one-cycle pulse coincident with the last window of the frame
//  busy_o    out  1         high from first accepted pixel until done_o
//  overrun_o out  1         sticky: valid_i seen during FLUSH; cleared only by reset
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; col/row counters 0. Line-delay contents are not cleared (masked by counters).
//  Slot index n = row*IMG_W + col of each accepted pixel.
//  Trigger rule: the window centred on slot m is produced by the slot-advance for slot m+IMG_W+1.
//  Latency: valid_o asserts exactly 1 clk after the triggering advance, with window_o registered.
//  Advance = (valid_i in IDLE/FILL/RUN) or (every cycle in FLUSH). No advance means all state holds.
//  FSM:
//   IDLE : first valid_i -> FILL; busy_o=1.
//   FILL : advance until slot IMG_W+1 is accepted -> RUN.
//   RUN  : steady state; accepting slot IMG_W*IMG_H-1 -> FLUSH (pad build) or -> IDLE (no pad).
//   FLUSH: internal advances with zero data for IMG_W+1 cycles -> IDLE; valid_i dropped, overrun_o set.
//  Column wrap: col==IMG_W-1 on advance -> col=0, row++. Frame end -> both 0.
//  Counters are $clog2(IMG_W) and $clog2(IMG_H) wide; no arithmetic overflow permitted.
//  done_o = valid_o for the final centre (IMG_H-2,IMG_W-2) without pad, or (IMG_H-1,IMG_W-1) with pad.
//  busy_o drops the cycle after done_o.
//  Reset mid-frame returns to IDLE immediately. The next pixel is treated as slot 0; no stale window is emitted.
//  Back-to-back frames: first valid_i in the cycle after RUN->IDLE is accepted as slot 0 of the next frame.
// CONFIGURATION
//  Macro GRAY_WIN_ZERO_PAD_EN:
//   defined   : a window is emitted for every centre (IMG_W*IMG_H per frame).
//               Taps outside the image are forced to 0 by row/col masks.
//               FLUSH state is present and drives the trailing IMG_W+1 windows.
//   undefined : windows are emitted only for interior centres 1<=r<=IMG_H-2, 1<=c<=IMG_W-2,
//               giving (IMG_W-2)*(IMG_H-2) per frame. No FLUSH state; overrun_o is tied to 0.
// STRUCTURE
//  Shared package/header img_pkg:
//   IMG_W/IMG_H/PIX_W defaults
//   FSM state encoding IDLE/FILL/RUN/FLUSH
//   window tap index localparams
//  Sub-module gray_line_delay: IMG_W-deep, PIX_W-wide shift/RAM delay with enable.
//   Instantiated twice, feeding a 3x3 register array plus a mask/output register stage.
// TESTING (IMG_W=4, IMG_H=4, gray_i = slot index 0..15, unless noted)
//  1 No pad, continuous valid_i.
//    -> 4 windows, the first 1 clk after slot 10: rows {0,1,2}/{4,5,6}/{8,9,10}.
//    -> last window {5,6,7}/{9,10,11}/{13,14,15} with done_o=1.
//  2 No pad, valid_i toggling 1/0 each cycle.
//    -> identical 4 windows in the same order; no valid_o during input gaps plus 1 clk.
//  3 Pad build.
//    -> 16 windows; first (after slot 5) {0,0,0}/{0,0,1}/{0,4,5}.
//    -> 5 FLUSH windows follow slot 15 on consecutive clks.
//    -> last window {10,11,0}/{14,15,0}/{0,0,0} with done_o=1.
//  4 Pad build, valid_i=1 during FLUSH.
//    -> input ignored, window sequence unchanged, overrun_o=1 until rst.
//  5 rst low after slot 7, then a fresh frame of values 100..115.
//    -> outputs 0 during reset; no window contains values 0..7; next frame's windows are correct.
//  6 Two frames back-to-back with no idle cycle.
//    -> two done_o pulses.
//    -> second frame's first window equals scenario 1/3 values offset by the frame-2 data.

Source files
------------

// File: rtl/img_pkg.sv
// Shared definitions for the grayscale 3x3 window stage: size defaults,
// FSM state encoding and window tap indexing (tap k = 3*row + col).
package img_pkg;

   localparam int unsigned IMG_W_DEF = 640;
   localparam int unsigned IMG_H_DEF = 480;
   localparam int unsigned PIX_W_DEF = 8;
   localparam int unsigned NUM_TAPS  = 9;

   localparam int unsigned ROW_OLD = 0;
   localparam int unsigned ROW_MID = 1;
   localparam int unsigned ROW_NEW = 2;
   localparam int unsigned COL_L   = 0;
   localparam int unsigned COL_M   = 1;
   localparam int unsigned COL_R   = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_RUN   = 2'd2,
      ST_FLUSH = 2'd3
   } win_state_e;

   function automatic int unsigned tap_idx(input int unsigned r, input int unsigned c);
      return 3 * r + c;
   endfunction

endpackage

// File: rtl/gray_line_delay.sv
// One-line pixel delay: dout is the pixel written DEPTH enabled cycles ago.
// Contents are never reset; the window stage masks anything stale.
module gray_line_delay #(
   parameter int unsigned DEPTH = 640,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (en) begin
         mem_d[0] = din;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/gray_window_3x3.sv
// Raster-order 3x3 neighbourhood builder for the grayscale stream.
// Define GRAY_WIN_ZERO_PAD_EN for a window at every pixel (zero-padded borders).
module gray_window_3x3
   import img_pkg::*;
#(
   parameter int unsigned IMG_W = IMG_W_DEF,
   parameter int unsigned IMG_H = IMG_H_DEF,
   parameter int unsigned PIX_W = PIX_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [PIX_W-1:0]   gray_i,
   input  logic               valid_i,
   output logic [9*PIX_W-1:0] window_o,
   output logic               valid_o,
   output logic               done_o,
   output logic               busy_o,
   output logic               overrun_o
);

   localparam int unsigned   CW       = $clog2(IMG_W);
   localparam int unsigned   RW       = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   win_state_e         state_q, state_d;
   logic [CW-1:0]      col_q, col_d;
   logic [RW-1:0]      row_q, row_d;
   logic [PIX_W-1:0]   win_q [NUM_TAPS];
   logic [PIX_W-1:0]   win_d [NUM_TAPS];
   logic [9*PIX_W-1:0] window_q, window_d;
   logic               valid_q, valid_d, done_q, done_d, busy_q, busy_d, ovr_q, ovr_d;
   logic               adv, in_flush, last_slot, emit, last_win;
   logic               mask_top, mask_bot, mask_left, mask_right;
   logic [PIX_W-1:0]   pix_in, ld1_out, ld2_out, tap;

`ifdef GRAY_WIN_ZERO_PAD_EN
   localparam int unsigned   FW      = $clog2(IMG_W + 1);
   localparam logic [FW-1:0] FL_LAST = FW'(IMG_W);
   logic [FW-1:0] fl_q, fl_d;
   assign in_flush = (state_q == ST_FLUSH);
`else
   assign in_flush = 1'b0;
`endif

   assign adv       = valid_i | in_flush;
   assign pix_in    = in_flush ? '0 : gray_i;
   assign last_slot = (row_q == ROW_LAST) && (col_q == COL_LAST);

   gray_line_delay #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_line1 (
      .clk(clk), .en(adv), .din(pix_in), .dout(ld1_out)
   );
   gray_line_delay #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_line2 (
      .clk(clk), .en(adv), .din(ld1_out), .dout(ld2_out)
   );

   always_comb begin
      state_d    = state_q;
      col_d      = col_q;
      row_d      = row_q;
      busy_d     = busy_q;
      ovr_d      = ovr_q;
      emit       = 1'b0;
      last_win   = 1'b0;
      mask_top   = 1'b0;
      mask_bot   = 1'b0;
      mask_left  = 1'b0;
      mask_right = 1'b0;
`ifdef GRAY_WIN_ZERO_PAD_EN
      fl_d       = fl_q;
`endif
      if (done_q) busy_d = 1'b0;

      if (adv && !in_flush) begin
         if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = last_slot ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
         unique case (state_q)
            ST_IDLE: begin
               state_d = ST_FILL;
               busy_d  = 1'b1;
            end
            ST_FILL: if (row_q == RW'(1) && col_q == CW'(1)) state_d = ST_RUN;
`ifdef GRAY_WIN_ZERO_PAD_EN
            ST_RUN:  if (last_slot) state_d = ST_FLUSH;
`else
            ST_RUN:  if (last_slot) state_d = ST_IDLE;
`endif
            default: ;
         endcase
      end

`ifdef GRAY_WIN_ZERO_PAD_EN
      // Centre trails the accepted slot by IMG_W+1; borders derived from the slot position.
      if (in_flush) begin
         if (valid_i) ovr_d = 1'b1;
         emit       = 1'b1;
         last_win   = (fl_q == FL_LAST);
         mask_right = (fl_q == '0) || (fl_q == FL_LAST);
         mask_bot   = (fl_q != '0);
         mask_left  = (fl_q == FW'(1));
         if (fl_q == FL_LAST) begin
            fl_d    = '0;
            state_d = ST_IDLE;
         end else begin
            fl_d = fl_q + 1'b1;
         end
      end else if (adv) begin
         emit       = (row_q >= RW'(2)) || (row_q == RW'(1) && col_q != '0);
         mask_top   = (row_q == RW'(1) && col_q != '0) || (row_q == RW'(2) && col_q == '0);
         mask_left  = (col_q == CW'(1));
         mask_right = (col_q == '0);
      end
`else
      emit     = adv && (row_q >= RW'(2)) && (col_q >= CW'(2));
      last_win = last_slot;
`endif
   end

   always_comb begin
      win_d = win_q;
      if (adv) begin
         for (int unsigned r = 0; r < 3; r++) begin
            win_d[tap_idx(r, COL_L)] = win_q[tap_idx(r, COL_M)];
            win_d[tap_idx(r, COL_M)] = win_q[tap_idx(r, COL_R)];
         end
         win_d[tap_idx(ROW_OLD, COL_R)] = ld2_out;
         win_d[tap_idx(ROW_MID, COL_R)] = ld1_out;
         win_d[tap_idx(ROW_NEW, COL_R)] = pix_in;
      end

      tap      = '0;
      window_d = window_q;
      valid_d  = emit;
      done_d   = emit && last_win;
      if (emit) begin
         for (int unsigned r = 0; r < 3; r++) begin
            for (int unsigned c = 0; c < 3; c++) begin
               tap = win_d[tap_idx(r, c)];
               if ((r == ROW_OLD && mask_top) || (r == ROW_NEW && mask_bot) ||
                   (c == COL_L && mask_left) || (c == COL_R && mask_right)) begin
                  tap = '0;
               end
               window_d[PIX_W*tap_idx(r, c) +: PIX_W] = tap;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      win_q <= win_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         col_q    <= '0;
         row_q    <= '0;
         window_q <= '0;
         valid_q  <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         ovr_q    <= 1'b0;
`ifdef GRAY_WIN_ZERO_PAD_EN
         fl_q     <= '0;
`endif
      end else begin
         state_q  <= state_d;
         col_q    <= col_d;
         row_q    <= row_d;
         window_q <= window_d;
         valid_q  <= valid_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         ovr_q    <= ovr_d;
`ifdef GRAY_WIN_ZERO_PAD_EN
         fl_q     <= fl_d;
`endif
      end
   end

   assign window_o  = window_q;
   assign valid_o   = valid_q;
   assign done_o    = done_q;
   assign busy_o    = busy_q;
   assign overrun_o = ovr_q;

endmodule

// File: tb/tb_gray_window_3x3.sv
// Bench for gray_window_3x3 on a 4x4 image; follows GRAY_WIN_ZERO_PAD_EN like the design.
module tb_gray_window_3x3;

   localparam int W   = 4;
   localparam int H   = 4;
   localparam int P   = 8;
   localparam int N   = W * H;
   localparam int LIM = 300;
`ifdef GRAY_WIN_ZERO_PAD_EN
   localparam bit PAD = 1'b1;
`else
   localparam bit PAD = 1'b0;
`endif
   localparam int NWIN = PAD ? N : (W - 2) * (H - 2);

   logic           clk = 1'b0;
   logic           rst;
   logic [P-1:0]   gray_i;
   logic           valid_i;
   logic [9*P-1:0] window_o;
   logic           valid_o, done_o, busy_o, overrun_o;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   gray_window_3x3 #(.IMG_W(W), .IMG_H(H), .PIX_W(P)) dut (
      .clk(clk), .rst(rst), .gray_i(gray_i), .valid_i(valid_i),
      .window_o(window_o), .valid_o(valid_o), .done_o(done_o),
      .busy_o(busy_o), .overrun_o(overrun_o)
   );

   // Reference model: frame image plus expected outputs after the latest edge.
   logic [P-1:0]   frame [N];
   int             slot, fl_left;
   logic           e_valid, e_done, e_busy, e_ovr;
   logic [9*P-1:0] e_win;

   task automatic model_reset();
      slot = 0; fl_left = 0;
      e_valid = 1'b0; e_done = 1'b0; e_busy = 1'b0; e_ovr = 1'b0; e_win = '0;
   endtask

   task automatic step(input logic v, input logic [P-1:0] d, output bit took);
      int s, m, cr, cc, y, x;
      bit adv;
      valid_i = v; gray_i = d; took = 1'b0; adv = 1'b0; s = 0;
      @(posedge clk);
      if (e_done) e_busy = 1'b0;
      e_valid = 1'b0; e_done = 1'b0;
      if (fl_left > 0) begin
         s = N + (W + 1 - fl_left);
         fl_left--;
         adv = 1'b1;
         if (v) e_ovr = 1'b1;
      end else if (v) begin
         frame[slot] = d; s = slot; took = 1'b1; adv = 1'b1;
         if (slot == 0) e_busy = 1'b1;
         slot++;
         if (slot == N) begin
            slot = 0;
            if (PAD) fl_left = W + 1;
         end
      end
      m = s - W - 1;
      if (adv && m >= 0) begin
         cr = m / W; cc = m % W;
         if (PAD || (cr >= 1 && cr <= H - 2 && cc >= 1 && cc <= W - 2)) begin
            e_valid = 1'b1;
            e_done  = PAD ? (m == N - 1) : (m == (H - 2) * W + W - 2);
            for (int r = 0; r < 3; r++) begin
               for (int c = 0; c < 3; c++) begin
                  y = cr - 1 + r; x = cc - 1 + c;
                  e_win[P*(3*r+c) +: P] = (y >= 0 && y < H && x >= 0 && x < W) ? frame[y*W+x] : '0;
               end
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      valid_i = 1'b0; gray_i = '0;
      rst = 1'b1;
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      tests++;
      if ({window_o, valid_o, done_o, busy_o, overrun_o} !== '0) begin
         fails++;
         $display("FAIL reset_state got win=%h v=%b d=%b b=%b o=%b want all 0", window_o, valid_o, done_o, busy_o, overrun_o);
      end
      rst = 1'b1;
      model_reset();
      @(negedge clk);
   endtask

   task automatic test_continuous();
      int exp_first[9], exp_last[9];
      logic [9*P-1:0] ef, el, first_w, last_w;
      bit took;
      int sent = 0, cyc = 0, nw = 0, nd = 0;
      if (PAD) begin
         exp_first = '{0, 0, 0, 0, 0, 1, 0, 4, 5};
         exp_last  = '{10, 11, 0, 14, 15, 0, 0, 0, 0};
      end else begin
         exp_first = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
         exp_last  = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
      end
      for (int k = 0; k < 9; k++) begin
         ef[P*k +: P] = P'(exp_first[k]);
         el[P*k +: P] = P'(exp_last[k]);
      end
      first_w = '0; last_w = '0;
      while ((sent < N || fl_left > 0 || e_valid) && cyc < LIM) begin
         step(sent < N, P'(sent), took);
         if (took) sent++;
         cyc++;
         tests++;
         if ({valid_o, done_o, busy_o, overrun_o} !== {e_valid, e_done, e_busy, e_ovr}) begin
            fails++;
            $display("FAIL cont_flags cyc=%0d got vdbo=%b want %b", cyc, {valid_o, done_o, busy_o, overrun_o}, {e_valid, e_done, e_busy, e_ovr});
         end
         if (e_valid) begin
            tests++;
            if (window_o !== e_win) begin
               fails++;
               $display("FAIL cont_window cyc=%0d got %h want %h", cyc, window_o, e_win);
            end
         end
         if (valid_o === 1'b1) begin
            if (nw == 0) first_w = window_o;
            last_w = window_o;
            nw++;
         end
         if (done_o === 1'b1) nd++;
      end
      tests++;
      if (cyc >= LIM || nw != NWIN || nd != 1) begin
         fails++;
         $display("FAIL cont_count got windows=%0d dones=%0d cyc=%0d want windows=%0d dones=1", nw, nd, cyc, NWIN);
      end
      tests++;
      if (first_w !== ef) begin
         fails++;
         $display("FAIL cont_first got %h want %h", first_w, ef);
      end
      tests++;
      if (last_w !== el) begin
         fails++;
         $display("FAIL cont_last got %h want %h", last_w, el);
      end
   endtask

   task automatic test_gaps(input bit toggle);
      bit took;
      logic v;
      int sent = 0, cyc = 0, nw = 0;
      while ((sent < N || fl_left > 0 || e_valid) && cyc < LIM) begin
         v = toggle ? ((cyc % 2) == 0) : ($urandom_range(0, 3) != 0);
         step(v && sent < N, P'($urandom), took);
         if (took) sent++;
         cyc++;
         tests++;
         if ({valid_o, done_o, busy_o, overrun_o} !== {e_valid, e_done, e_busy, e_ovr}) begin
            fails++;
            $display("FAIL gaps%0d_flags cyc=%0d got vdbo=%b want %b", toggle, cyc, {valid_o, done_o, busy_o, overrun_o}, {e_valid, e_done, e_busy, e_ovr});
         end
         if (e_valid) begin
            tests++;
            if (window_o !== e_win) begin
               fails++;
               $display("FAIL gaps%0d_window cyc=%0d got %h want %h", toggle, cyc, window_o, e_win);
            end
         end
         if (valid_o === 1'b1) nw++;
      end
      tests++;
      if (cyc >= LIM || nw != NWIN) begin
         fails++;
         $display("FAIL gaps%0d_count got windows=%0d cyc=%0d want %0d", toggle, nw, cyc, NWIN);
      end
   endtask

   task automatic test_overrun();
      bit took;
      int sent = 0, cyc = 0;
      while ((sent < N || fl_left > 0 || e_valid) && cyc < LIM) begin
         step(sent < N || fl_left > 0, P'($urandom), took);
         if (took) sent++;
         cyc++;
         tests++;
         if ({valid_o, done_o, busy_o, overrun_o} !== {e_valid, e_done, e_busy, e_ovr}) begin
            fails++;
            $display("FAIL ovr_flags cyc=%0d got vdbo=%b want %b", cyc, {valid_o, done_o, busy_o, overrun_o}, {e_valid, e_done, e_busy, e_ovr});
         end
         if (e_valid) begin
            tests++;
            if (window_o !== e_win) begin
               fails++;
               $display("FAIL ovr_window cyc=%0d got %h want %h", cyc, window_o, e_win);
            end
         end
      end
      repeat (3) step(1'b0, '0, took);
      tests++;
      if (cyc >= LIM || overrun_o !== PAD) begin
         fails++;
         $display("FAIL ovr_sticky got %b cyc=%0d want %b", overrun_o, cyc, PAD);
      end
   endtask

   task automatic test_reset_midframe();
      bit took;
      int sent = 0, cyc = 0;
      for (int i = 0; i < 8; i++) step(1'b1, P'(i), took);
      #2 rst = 1'b0;
      #1;
      tests++;
      if ({window_o, valid_o, done_o, busy_o, overrun_o} !== '0) begin
         fails++;
         $display("FAIL rst_mid_async got win=%h vdbo=%b want 0", window_o, {valid_o, done_o, busy_o, overrun_o});
      end
      valid_i = 1'b1; gray_i = 8'd3;
      repeat (2) @(negedge clk);
      tests++;
      if ({window_o, valid_o, done_o, busy_o, overrun_o} !== '0) begin
         fails++;
         $display("FAIL rst_mid_hold got win=%h vdbo=%b want 0", window_o, {valid_o, done_o, busy_o, overrun_o});
      end
      valid_i = 1'b0;
      rst = 1'b1;
      model_reset();
      while ((sent < N || fl_left > 0 || e_valid) && cyc < LIM) begin
         step(sent < N, P'(100 + sent), took);
         if (took) sent++;
         cyc++;
         tests++;
         if ({valid_o, done_o, busy_o, overrun_o} !== {e_valid, e_done, e_busy, e_ovr}) begin
            fails++;
            $display("FAIL rst_flags cyc=%0d got vdbo=%b want %b", cyc, {valid_o, done_o, busy_o, overrun_o}, {e_valid, e_done, e_busy, e_ovr});
         end
         if (e_valid) begin
            tests++;
            if (window_o !== e_win) begin
               fails++;
               $display("FAIL rst_window cyc=%0d got %h want %h", cyc, window_o, e_win);
            end
         end
         if (valid_o === 1'b1) begin
            for (int k = 0; k < 9; k++) begin
               tests++;
               if (window_o[P*k +: P] < 8'd100 && !(PAD && window_o[P*k +: P] == 8'd0)) begin
                  fails++;
                  $display("FAIL rst_stale tap=%0d got %0d want >=100", k, window_o[P*k +: P]);
               end
            end
         end
      end
      tests++;
      if (cyc >= LIM) begin
         fails++;
         $display("FAIL rst_timeout got cyc=%0d want <%0d", cyc, LIM);
      end
   endtask

   task automatic test_back_to_back();
      bit took;
      int sent = 0, cyc = 0, nd = 0;
      while ((sent < 2 * N || fl_left > 0 || e_valid) && cyc < LIM) begin
         step(sent < 2 * N, P'($urandom), took);
         if (took) sent++;
         cyc++;
         tests++;
         if ({valid_o, done_o, busy_o, overrun_o} !== {e_valid, e_done, e_busy, e_ovr}) begin
            fails++;
            $display("FAIL b2b_flags cyc=%0d got vdbo=%b want %b", cyc, {valid_o, done_o, busy_o, overrun_o}, {e_valid, e_done, e_busy, e_ovr});
         end
         if (e_valid) begin
            tests++;
            if (window_o !== e_win) begin
               fails++;
               $display("FAIL b2b_window cyc=%0d got %h want %h", cyc, window_o, e_win);
            end
         end
         if (done_o === 1'b1) nd++;
      end
      tests++;
      if (cyc >= LIM || nd != 2) begin
         fails++;
         $display("FAIL b2b_dones got %0d cyc=%0d want 2", nd, cyc);
      end
   endtask

   initial begin
      test_reset();
      test_continuous();
      test_gaps(1'b1);
      test_gaps(1'b0);
      test_overrun();
      test_reset_midframe();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
